// File: rtl/seq_argmax_pkg.sv
// Shared types and helpers for the argmax output stage that follows the ternary XNOR layer.
package seq_argmax_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    SCAN = 1'b1
  } state_e;

  // Lane width of the packed accumulator sums produced by the ternary layer.
  localparam int SUM_L = 8;

  function automatic int idx_w(input int m);
    return (m > 1) ? $clog2(m) : 1;
  endfunction

  function automatic logic lane_gt(input logic [SUM_L-1:0] a,
                                   input logic [SUM_L-1:0] b,
                                   input logic             is_signed);
    if (is_signed) begin
      return $signed(a) > $signed(b);
    end
    return a > b;
  endfunction

endpackage

// File: rtl/seq_argmax.sv
// Sequential argmax: snapshots M packed sums on start, scans one lane per cycle with a
// single comparator, and pulses done with the winning index and value.
module seq_argmax
  import seq_argmax_pkg::*;
#(
  parameter int M      = 4,
  parameter int SumL   = SUM_L,
  parameter bit SIGNED = 1'b1,
  localparam int IdxW  = idx_w(M)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [M*SumL-1:0] sums,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic [IdxW-1:0]   class_idx,
  output logic [SumL-1:0]   class_val
);

  localparam logic [IdxW-1:0] LAST_IDX = IdxW'(M - 1);

  state_e                   state_q, state_d;
  logic [M-1:0][SumL-1:0]   snap_q, snap_d;
  logic [SumL-1:0]          best_val_q, best_val_d;
  logic [IdxW-1:0]          best_idx_q, best_idx_d;
  logic [IdxW-1:0]          ptr_q, ptr_d;
  logic [IdxW-1:0]          class_idx_q, class_idx_d;
  logic [SumL-1:0]          class_val_q, class_val_d;
  logic                     done_q, done_d;
  logic [SumL-1:0]          cur_lane;

  assign cur_lane = snap_q[ptr_q];

  always_comb begin
    state_d     = state_q;
    snap_d      = snap_q;
    best_val_d  = best_val_q;
    best_idx_d  = best_idx_q;
    ptr_d       = ptr_q;
    class_idx_d = class_idx_q;
    class_val_d = class_val_q;
    done_d      = 1'b0;

    case (state_q)
      IDLE: begin
        if (start) begin
          snap_d     = sums;
          best_val_d = sums[SumL-1:0];
          best_idx_d = '0;
          if (M == 1) begin
            // A single lane is its own maximum: finish on the start edge.
            ptr_d       = '0;
            done_d      = 1'b1;
            class_idx_d = '0;
            class_val_d = sums[SumL-1:0];
          end else begin
            ptr_d   = IdxW'(1);
            state_d = SCAN;
          end
        end
      end
      SCAN: begin
        // Strictly greater only, so ties keep the lower index.
        if (lane_gt(cur_lane, best_val_q, SIGNED)) begin
          best_val_d = cur_lane;
          best_idx_d = ptr_q;
        end
        if (ptr_q == LAST_IDX) begin
          state_d     = IDLE;
          done_d      = 1'b1;
          class_idx_d = best_idx_d;
          class_val_d = best_val_d;
        end else begin
          ptr_d = ptr_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      snap_q      <= '0;
      best_val_q  <= '0;
      best_idx_q  <= '0;
      ptr_q       <= '0;
      class_idx_q <= '0;
      class_val_q <= '0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      snap_q      <= snap_d;
      best_val_q  <= best_val_d;
      best_idx_q  <= best_idx_d;
      ptr_q       <= ptr_d;
      class_idx_q <= class_idx_d;
      class_val_q <= class_val_d;
      done_q      <= done_d;
    end
  end

  assign busy      = (state_q == SCAN);
  assign done      = done_q;
  assign class_idx = class_idx_q;
  assign class_val = class_val_q;

endmodule

// File: tb/tb_seq_argmax.sv
// Scoreboard bench for seq_argmax: signed M=4, unsigned M=4 and M=1 instances share one stimulus stream.
module tb_seq_argmax;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [31:0] sums;

  logic       busy_s, done_s, busy_u, done_u, busy_1, done_1;
  logic [1:0] idx_s, idx_u;
  logic [0:0] idx_1;
  logic [7:0] val_s, val_u, val_1;

  always #5 clk = ~clk;

  seq_argmax #(.M(4), .SumL(8), .SIGNED(1'b1)) dut_s (
    .clk(clk), .rst(rst), .sums(sums), .start(start),
    .busy(busy_s), .done(done_s), .class_idx(idx_s), .class_val(val_s));

  seq_argmax #(.M(4), .SumL(8), .SIGNED(1'b0)) dut_u (
    .clk(clk), .rst(rst), .sums(sums), .start(start),
    .busy(busy_u), .done(done_u), .class_idx(idx_u), .class_val(val_u));

  seq_argmax #(.M(1), .SumL(8), .SIGNED(1'b1)) dut_1 (
    .clk(clk), .rst(rst), .sums(sums[7:0]), .start(start),
    .busy(busy_1), .done(done_1), .class_idx(idx_1), .class_val(val_1));

  typedef struct {
    int acc;
    int due;
    int idx;
    int val;
  } exp_t;

  exp_t q[3][$];
  int   hold_idx[3];
  int   hold_val[3];
  int   n_chk  = 0;
  int   n_fail = 0;
  int   edge_n = 0;
  logic rst_seen = 1'b0;
  int   free4  = 0;

  always @(posedge clk) begin
    edge_n   <= edge_n + 1;
    rst_seen <= rst;
  end

  task automatic chk(input string nm, input int act, input int exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s edge=%0d actual=%0d expected=%0d", nm, edge_n, act, exp);
    end
  endtask

  // Largest lane wins; on equal values the first (lowest) lane is kept.
  task automatic ref_argmax(input logic [31:0] v, input bit sgn, output int idx, output int val);
    int bestv;
    logic [7:0] lane;
    int s;
    bestv = 0;
    idx   = 0;
    val   = 0;
    for (int j = 0; j < 4; j++) begin
      lane = v[j*8 +: 8];
      s    = sgn ? int'($signed(lane)) : int'(lane);
      if (j == 0 || s > bestv) begin
        bestv = s;
        idx   = j;
        val   = int'(lane);
      end
    end
  endtask

  task automatic drive(input logic s, input logic [31:0] v, input logic r);
    int e;
    int i;
    int vv;
    e     = edge_n + 1;
    rst   = r;
    start = s;
    sums  = v;
    if (r) begin
      free4 = e + 1;
    end else if (s) begin
      q[2].push_back('{acc: e, due: e, idx: 0, val: int'(v[7:0])});
      if (e >= free4) begin
        ref_argmax(v, 1'b1, i, vv);
        q[0].push_back('{acc: e, due: e + 3, idx: i, val: vv});
        ref_argmax(v, 1'b0, i, vv);
        q[1].push_back('{acc: e, due: e + 3, idx: i, val: vv});
        free4 = e + 4;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic mon(input int d, input logic dn, input logic bsy, input int idx, input int val);
    exp_t e;
    logic bexp;
    string nm;
    nm = $sformatf("dut%0d", d);
    if (rst_seen) begin
      hold_idx[d] = 0;
      hold_val[d] = 0;
      while (q[d].size() > 0 && q[d][0].acc <= edge_n) void'(q[d].pop_front());
    end
    if (dn) begin
      if (q[d].size() == 0) begin
        n_chk++;
        n_fail++;
        $display("FAIL %s unexpected_done edge=%0d actual=1 expected=0", nm, edge_n);
      end else begin
        e = q[d].pop_front();
        chk({nm, " done_edge"}, edge_n, e.due);
        chk({nm, " done_idx"}, idx, e.idx);
        chk({nm, " done_val"}, val, e.val);
        hold_idx[d] = e.idx;
        hold_val[d] = e.val;
      end
    end else if (q[d].size() > 0 && q[d][0].due <= edge_n) begin
      chk({nm, " missing_done_due_edge"}, edge_n, q[d][0].due);
      void'(q[d].pop_front());
    end
    bexp = (d != 2) && (q[d].size() > 0) && (q[d][0].acc <= edge_n) && (edge_n < q[d][0].due);
    chk({nm, " busy"}, int'(bsy), int'(bexp));
    chk({nm, " class_idx_hold"}, idx, hold_idx[d]);
    chk({nm, " class_val_hold"}, val, hold_val[d]);
  endtask

  always @(negedge clk) begin
    mon(0, done_s, busy_s, int'(idx_s), int'(val_s));
    mon(1, done_u, busy_u, int'(idx_u), int'(val_u));
    mon(2, done_1, busy_1, int'(idx_1), int'(val_1));
  end

  initial begin
    logic [31:0] v;
    for (int d = 0; d < 3; d++) begin
      hold_idx[d] = 0;
      hold_val[d] = 0;
    end
    rst = 1'b1;
    start = 1'b0;
    sums = '0;
    repeat (3) drive(1'b0, 32'h0, 1'b1);
    repeat (2) drive(1'b0, 32'h0, 1'b0);

    // Lanes {3,-2,7,5}
    v = {8'd5, 8'd7, 8'hFE, 8'd3};
    drive(1'b1, v, 1'b0);
    repeat (5) drive(1'b0, v, 1'b0);
    // Ties, all -128, and the sign-sensitive vector
    v = {8'd1, 8'd9, 8'd9, 8'd4};
    drive(1'b1, v, 1'b0);
    repeat (4) drive(1'b0, v, 1'b0);
    v = {4{8'h80}};
    drive(1'b1, v, 1'b0);
    repeat (4) drive(1'b0, v, 1'b0);
    v = {8'h00, 8'h00, 8'h7F, 8'h80};
    drive(1'b1, v, 1'b0);
    repeat (4) drive(1'b0, v, 1'b0);

    // Snapshot isolation with start held high through two scans
    v = {8'd1, 8'd2, 8'd3, 8'hF0};
    drive(1'b1, v, 1'b0);
    for (int i = 0; i < 7; i++) drive(1'b1, $urandom, 1'b0);
    repeat (5) drive(1'b0, 32'h0, 1'b0);

    // Reset during the second scan cycle, then a clean scan
    v = {8'd10, 8'd20, 8'd30, 8'd40};
    drive(1'b1, v, 1'b0);
    drive(1'b0, v, 1'b0);
    drive(1'b0, v, 1'b1);
    drive(1'b0, 32'h0, 1'b0);
    v = {8'h81, 8'h7E, 8'h00, 8'hC0};
    drive(1'b1, v, 1'b0);
    repeat (5) drive(1'b0, v, 1'b0);

    for (int i = 0; i < 400; i++) begin
      drive($urandom_range(0, 99) < 40, $urandom, $urandom_range(0, 99) < 2);
    end
    repeat (6) drive(1'b0, 32'h0, 1'b0);

    for (int d = 0; d < 3; d++) chk($sformatf("dut%0d drained", d), q[d].size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
